// File: rtl/decode_stage.sv
// RV32I decode stage: one-cycle registered decode of each accepted instruction, load-use bubbles, JAL redirect plus one-slot squash.
// Backpressure: the payload holds while out_valid && !out_ready, and in_ready drops for a stalled output or a load-use hazard.
module decode_stage #(
  parameter int ADDRESS_BITS = 16,
  parameter int CNT_BITS     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    branch_op,
  output logic signed [31:0]      imm32,
  output logic [1:0]              op_A_sel,
  output logic                    op_B_sel,
  output logic [5:0]              ALU_Control,
  output logic                    mem_wEn,
  output logic                    mem_rEn,
  output logic                    wb_sel,
  output logic                    illegal,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic [CNT_BITS-1:0]     stall_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        br;
    logic [31:0] imm;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [5:0]  alu;
    logic        mw;
    logic        mr;
    logic        wb;
    logic        ill;
  } dec_t;

  dec_t                    dec, dec_q;
  logic [ADDRESS_BITS-1:0] pc_q, target_q, target_d;
  logic                    out_valid_q, out_valid_d;
  logic                    squash_q, squash_d;
  logic                    npc_q, npc_d;
  logic [CNT_BITS-1:0]     stall_q, stall_d;
  logic                    uses_rs1, uses_rs2, is_jal;
  logic                    load_use, accept, keep;
  logic [2:0]              f3;

  assign f3     = instruction[14:12];
  assign is_jal = (instruction[6:0] == OP_JAL);

  always_comb begin
    dec       = '0;
    dec.rs1   = instruction[19:15];
    dec.rs2   = instruction[24:20];
    dec.rd    = instruction[11:7];
    dec.b_sel = 1'b1;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    case (instruction[6:0])
      OP_R: begin
        dec.b_sel = 1'b0;
        dec.wen   = 1'b1;
        dec.alu   = {2'b00, instruction[30] & ((f3 == 3'b000) | (f3 == 3'b101)), f3};
        uses_rs2  = 1'b1;
      end
      OP_I: begin
        dec.imm = {{20{instruction[31]}}, instruction[31:20]};
        dec.wen = 1'b1;
        dec.alu = {2'b00, instruction[30] & (f3 == 3'b101), f3};
      end
      OP_LOAD: begin
        dec.imm = {{20{instruction[31]}}, instruction[31:20]};
        dec.wen = 1'b1;
        dec.mr  = 1'b1;
        dec.wb  = 1'b1;
      end
      OP_STORE: begin
        dec.imm  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        dec.mw   = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm   = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
        dec.br    = 1'b1;
        dec.b_sel = 1'b0;
        dec.alu   = {3'b010, f3};
        uses_rs2  = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm   = {instruction[31:12], 12'h000};
        dec.wen   = 1'b1;
        dec.a_sel = (instruction[6:0] == OP_LUI) ? 2'b11 : 2'b01;
        uses_rs1  = 1'b0;
      end
      OP_JAL: begin
        dec.imm   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
        dec.wen   = 1'b1;
        dec.a_sel = 2'b10;
        dec.alu   = 6'b011111;
        uses_rs1  = 1'b0;
      end
      OP_JALR: begin
        dec.imm   = {{20{instruction[31]}}, instruction[31:20]};
        dec.wen   = 1'b1;
        dec.a_sel = 2'b10;
        dec.alu   = 6'b011111;
      end
      OP_FENCE, OP_SYSTEM: begin
        dec.imm = {{20{instruction[31]}}, instruction[31:20]};
      end
      default: begin
        // Unknown opcode decodes as addi x0,x0,0 flagged illegal.
        dec.rs1  = 5'd0;
        dec.rs2  = 5'd0;
        dec.rd   = 5'd0;
        dec.ill  = 1'b1;
        uses_rs1 = 1'b0;
      end
    endcase
    if (dec.rd == 5'd0) dec.wen = 1'b0;
  end

  assign load_use = out_valid_q & dec_q.mr & (dec_q.rd != 5'd0) & in_valid &
                    ((uses_rs1 & (dec.rs1 == dec_q.rd)) | (uses_rs2 & (dec.rs2 == dec_q.rd)));
  assign in_ready = flush | ((~out_valid_q | out_ready) & ~load_use);
  assign accept   = in_valid & in_ready;
  assign keep     = accept & ~flush & ~squash_q;

  always_comb begin
    out_valid_d = out_valid_q;
    squash_d    = squash_q;
    npc_d       = keep & is_jal;
    target_d    = target_q;
    stall_d     = stall_q;
    if (flush) begin
      out_valid_d = 1'b0;
      squash_d    = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      out_valid_d = keep;
      if (accept) squash_d = ~squash_q & is_jal;
      if (load_use && (stall_q != {CNT_BITS{1'b1}}))
        stall_d = stall_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end
    if (keep && is_jal) target_d = PC + dec.imm[ADDRESS_BITS-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      squash_q    <= 1'b0;
      npc_q       <= 1'b0;
      target_q    <= '0;
      stall_q     <= '0;
      dec_q       <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      squash_q    <= squash_d;
      npc_q       <= npc_d;
      target_q    <= target_d;
      stall_q     <= stall_d;
      if (keep) begin
        dec_q <= dec;
        pc_q  <= PC;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_PC         = pc_q;
  assign read_sel1      = dec_q.rs1;
  assign read_sel2      = dec_q.rs2;
  assign write_sel      = dec_q.rd;
  assign wEn            = dec_q.wen;
  assign branch_op      = dec_q.br;
  assign imm32          = $signed(dec_q.imm);
  assign op_A_sel       = dec_q.a_sel;
  assign op_B_sel       = dec_q.b_sel;
  assign ALU_Control    = dec_q.alu;
  assign mem_wEn        = dec_q.mw;
  assign mem_rEn        = dec_q.mr;
  assign wb_sel         = dec_q.wb;
  assign illegal        = dec_q.ill;
  assign next_PC_select = npc_q;
  assign target_PC      = target_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: transaction-level reference model checked every cycle,
// directed literal scenarios followed by randomized traffic.
module tb_decode_stage;
  localparam int AB = 16;
  localparam int CB = 16;

  logic              clock = 1'b0;
  logic              reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [AB-1:0]     PC, out_PC, target_PC;
  logic [31:0]       instruction;
  logic [4:0]        read_sel1, read_sel2, write_sel;
  logic              wEn, branch_op, op_B_sel, mem_wEn, mem_rEn, wb_sel, illegal, next_PC_select;
  logic signed [31:0] imm32;
  logic [1:0]        op_A_sel;
  logic [5:0]        ALU_Control;
  logic [CB-1:0]     stall_count;

  always #5 clock = ~clock;

  decode_stage #(.ADDRESS_BITS(AB), .CNT_BITS(CB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .PC(PC), .instruction(instruction), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_PC(out_PC),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
    .wEn(wEn), .branch_op(branch_op), .imm32(imm32), .op_A_sel(op_A_sel),
    .op_B_sel(op_B_sel), .ALU_Control(ALU_Control), .mem_wEn(mem_wEn),
    .mem_rEn(mem_rEn), .wb_sel(wb_sel), .illegal(illegal),
    .next_PC_select(next_PC_select), .target_PC(target_PC), .stall_count(stall_count)
  );

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic        wen, br;
    logic [31:0] imm;
    logic [1:0]  a;
    logic        b;
    logic [5:0]  alu;
    logic        mw, mr, wb, ill;
  } dec_t;

  int n_chk = 0;
  int n_fail = 0;

  logic          m_vld, m_npc, m_sq;
  dec_t          m_d;
  logic [AB-1:0] m_pc, m_tgt;
  logic [CB-1:0] m_stall;

  localparam logic [31:0] ADDI  = 32'hFFF00593; // addi x11,x0,-1
  localparam logic [31:0] ADD16 = 32'h00C58833; // add x16,x11,x12
  localparam logic [31:0] LW    = 32'h0005A903; // lw x18,0(x11)
  localparam logic [31:0] ADDH  = 32'h001902B3; // add x5,x18,x1
  localparam logic [31:0] ADDN  = 32'h002082B3; // add x5,x1,x2
  localparam logic [31:0] JAL1  = 32'h0140006F; // jal x0,+0x14
  localparam logic [31:0] JAL2  = 32'h0200006F; // jal x0,+0x20

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic byte fmt_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h33: return "R";
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: return "I";
      7'h23: return "S";
      7'h63: return "B";
      7'h37, 7'h17: return "U";
      7'h6F: return "J";
      default: return "X";
    endcase
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] half;
    half = 32'd1 << (n - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic dec_t ref_dec(input logic [31:0] ins);
    dec_t d;
    byte  f;
    int   f3;
    f  = fmt_of(ins);
    f3 = int'(ins[14:12]);
    d  = '0;
    d.b = 1'b1;
    if (f == "X") begin
      d.ill = 1'b1;
      return d;
    end
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    case (f)
      "I": d.imm = sext(32'(ins[31:20]), 12);
      "S": d.imm = sext(32'({ins[31:25], ins[11:7]}), 12);
      "B": d.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      "U": d.imm = {ins[31:12], 12'h000};
      "J": d.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      default: d.imm = 32'd0;
    endcase
    case (ins[6:0])
      7'h33: begin d.b = 1'b0; d.wen = 1'b1; d.alu = 6'(f3 + ((ins[30] && (f3 == 0 || f3 == 5)) ? 8 : 0)); end
      7'h13: begin d.wen = 1'b1; d.alu = 6'(f3 + ((ins[30] && f3 == 5) ? 8 : 0)); end
      7'h03: begin d.wen = 1'b1; d.mr = 1'b1; d.wb = 1'b1; end
      7'h23: d.mw = 1'b1;
      7'h63: begin d.br = 1'b1; d.b = 1'b0; d.alu = 6'(16 + f3); end
      7'h37: begin d.wen = 1'b1; d.a = 2'd3; end
      7'h17: begin d.wen = 1'b1; d.a = 2'd1; end
      7'h6F, 7'h67: begin d.wen = 1'b1; d.a = 2'd2; d.alu = 6'd31; end
      default: ;
    endcase
    if (d.rd == 5'd0) d.wen = 1'b0;
    return d;
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_npc = 1'b0; m_sq = 1'b0; m_d = '0;
    m_pc = '0; m_tgt = '0; m_stall = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("next_PC_select", 64'(next_PC_select), 64'(m_npc));
    chk("target_PC", 64'(target_PC), 64'(m_tgt));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
    if (m_vld) begin
      chk("out_PC", 64'(out_PC), 64'(m_pc));
      chk("read_sel1", 64'(read_sel1), 64'(m_d.rs1));
      chk("read_sel2", 64'(read_sel2), 64'(m_d.rs2));
      chk("write_sel", 64'(write_sel), 64'(m_d.rd));
      chk("wEn", 64'(wEn), 64'(m_d.wen));
      chk("branch_op", 64'(branch_op), 64'(m_d.br));
      chk("imm32", 64'($unsigned(imm32)), 64'(m_d.imm));
      chk("op_A_sel", 64'(op_A_sel), 64'(m_d.a));
      chk("op_B_sel", 64'(op_B_sel), 64'(m_d.b));
      chk("ALU_Control", 64'(ALU_Control), 64'(m_d.alu));
      chk("mem_wEn", 64'(mem_wEn), 64'(m_d.mw));
      chk("mem_rEn", 64'(mem_rEn), 64'(m_d.mr));
      chk("wb_sel", 64'(wb_sel), 64'(m_d.wb));
      chk("illegal", 64'(illegal), 64'(m_d.ill));
    end
  endtask

  // Inputs are set just after a rising edge; this evaluates the handshake mid-cycle and checks registered results after the edge.
  task automatic cycle();
    byte  fi;
    dec_t dn;
    logic hazard, exp_rdy, acc;
    logic          n_vld, n_npc, n_sq;
    dec_t          n_d;
    logic [AB-1:0] n_pc, n_tgt;
    logic [CB-1:0] n_stall;
    @(negedge clock);
    fi = fmt_of(instruction);
    dn = ref_dec(instruction);
    hazard = m_vld && m_d.mr && (m_d.rd != 5'd0) && in_valid &&
             ((fi != "U" && fi != "J" && fi != "X" && instruction[19:15] == m_d.rd) ||
              ((fi == "R" || fi == "S" || fi == "B") && instruction[24:20] == m_d.rd));
    exp_rdy = flush || ((!m_vld || out_ready) && !hazard);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    n_vld = m_vld; n_sq = m_sq; n_npc = 1'b0; n_d = m_d; n_pc = m_pc; n_tgt = m_tgt; n_stall = m_stall;
    if (flush) begin
      n_vld = 1'b0;
      n_sq  = 1'b0;
    end else begin
      if (hazard && out_ready && m_stall != {CB{1'b1}}) n_stall = m_stall + 1'b1;
      if (acc && m_sq) begin
        n_vld = 1'b0;
        n_sq  = 1'b0;
      end else if (acc) begin
        n_vld = 1'b1;
        n_d   = dn;
        n_pc  = PC;
        if (instruction[6:0] == 7'h6F) begin
          n_npc = 1'b1;
          n_sq  = 1'b1;
          n_tgt = PC + dn.imm[AB-1:0];
        end
      end else if (out_ready) begin
        n_vld = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    m_vld = n_vld; m_sq = n_sq; m_npc = n_npc; m_d = n_d; m_pc = n_pc; m_tgt = n_tgt; m_stall = n_stall;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [AB-1:0] pc,
                       input logic rdy, input logic fl);
    in_valid = v; instruction = ins; PC = pc; out_ready = rdy; flush = fl;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h6F;
      8: op = 7'h67;  9: op = 7'h73;  10: op = 7'h7F;
      default: op = r[6:0];
    endcase
    r[6:0]   = op;
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm32", 64'($unsigned(imm32)), 64'd0);
    chk("rst_target", 64'(target_PC), 64'd0);
    reset = 1'b1;

    drive(1'b1, ADDI, 16'h0100, 1'b1, 1'b0); cycle();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", 64'($unsigned(imm32)), 64'hFFFFFFFF);
    chk("addi_wsel", 64'(write_sel), 64'd11);
    drive(1'b1, ADD16, 16'h0104, 1'b1, 1'b0); cycle();
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_wsel", 64'(write_sel), 64'd16);

    drive(1'b1, LW, 16'h0108, 1'b1, 1'b0); cycle();
    chk("lw_rEn", 64'(mem_rEn), 64'd1);
    drive(1'b1, ADDH, 16'h010C, 1'b1, 1'b0); #1;
    chk("lu_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("lu_bubble", 64'(out_valid), 64'd0);
    chk("lu_stall", 64'(stall_count), 64'd1);
    cycle();
    chk("lu_emit", 64'(out_valid), 64'd1);
    chk("lu_emit_pc", 64'(out_PC), 64'h010C);
    drive(1'b1, LW, 16'h0110, 1'b1, 1'b0); cycle();
    drive(1'b1, ADDN, 16'h0114, 1'b1, 1'b0); #1;
    chk("nolu_in_ready", 64'(in_ready), 64'd1);
    cycle();
    chk("nolu_valid", 64'(out_valid), 64'd1);
    chk("nolu_stall", 64'(stall_count), 64'd1);

    drive(1'b1, JAL1, 16'h0114, 1'b1, 1'b0); cycle();
    chk("jal_npc", 64'(next_PC_select), 64'd1);
    chk("jal_target", 64'(target_PC), 64'h0128);
    drive(1'b1, ADDI, 16'h0118, 1'b1, 1'b0); cycle();
    chk("jal_squash", 64'(out_valid), 64'd0);
    chk("jal_npc_once", 64'(next_PC_select), 64'd0);
    drive(1'b1, JAL2, 16'hFFF0, 1'b1, 1'b0); cycle();
    chk("jal_wrap", 64'(target_PC), 64'h0010);
    drive(1'b1, ADD16, 16'hFFF4, 1'b1, 1'b0); cycle();
    chk("wrap_squash", 64'(out_valid), 64'd0);

    drive(1'b1, 32'hFFFFFFFF, 16'h0200, 1'b1, 1'b0); cycle();
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_wEn", 64'(wEn), 64'd0);
    chk("ill_mem_wEn", 64'(mem_wEn), 64'd0);
    chk("ill_wsel", 64'(write_sel), 64'd0);
    chk("ill_valid", 64'(out_valid), 64'd1);

    drive(1'b1, ADD16, 16'h0300, 1'b1, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, LW, 16'h0304, 1'b0, 1'b0); #1;
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      cycle();
      chk("hold_pc", 64'(out_PC), 64'h0300);
      chk("hold_wsel", 64'(write_sel), 64'd16);
    end
    drive(1'b1, LW, 16'h0304, 1'b0, 1'b1); cycle();
    chk("flush_clear", 64'(out_valid), 64'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, LW, 16'h0308, 1'b1, 1'b0); cycle();
      drive(1'b1, ADDH, 16'h030C, 1'b1, 1'b0); cycle(); cycle();
    end
    chk("stall5", 64'(stall_count), 64'd5);
    drive(1'b1, JAL1, 16'h0400, 1'b1, 1'b0); cycle();
    drive(1'b0, 32'd0, '0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_npc", 64'(next_PC_select), 64'd0);
    chk("arst_target", 64'(target_PC), 64'd0);
    chk("arst_stall", 64'(stall_count), 64'd0);
    chk("arst_wsel", 64'(write_sel), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(1'b1, ADDI, 16'h0500, 1'b1, 1'b0); cycle();
    chk("post_rst_emit", 64'(out_valid), 64'd1);
    chk("post_rst_wsel", 64'(write_sel), 64'd11);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, rand_ins(), AB'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
